sram_arbiter: RTL and testbench

- Parametrised N-channel arbiter that serialises CPU read/write requests onto one asynchronous SRAM port. It is the successor to IOhandler.
- Adds round-robin fairness, a configurable access length, and an explicit tristate drive-enable for the external tristate buffer.
- Sits between the CPU request buses and tristate/SRAM (test_memory in simulation).

---
 rtl/sram_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that serialises NUM_CH CPU read/write requests onto a single
// asynchronous SRAM port. Each access holds the selected strobe low for ACCESS_CYCLES cycles, then
// spends one DONE cycle with both strobes high while the address is held, and pulses requestDone.
//
// Ports:
//   Clk, reset_n        clock (rising edge), asynchronous active-low reset
//   writeRequest        per-channel write request (level); wins over readRequest on the same channel
//   readRequest         per-channel read request (level)
//   addr_in, data_in    packed per-channel address / write data, channel i at [i*W +: W]
//   addressToSRAM       SRAM address, stable through ACCESS and DONE
//   sram_wdata          write data to the tristate buffer
//   sram_rdata          read data from the tristate buffer
//   sram_data_oe        tristate drive enable (1 = drive bus), only during a write access
//   SRAM_WE, SRAM_RE    active-low write / output enables
//   DataToCPUs          data of the last completed read, shared by all channels
//   requestDone         one-hot, one-cycle completion pulse
//   busy                high whenever the FSM is not idle
module sram_arbiter #(
   parameter int unsigned NUM_CH        = 5,
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic                     Clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        writeRequest,
   input  logic [NUM_CH-1:0]        readRequest,
   input  logic [NUM_CH*ADDR_W-1:0] addr_in,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0]        addressToSRAM,
   output logic [DATA_W-1:0]        sram_wdata,
   input  logic [DATA_W-1:0]        sram_rdata,
   output logic                     sram_data_oe,
   output logic                     SRAM_WE,
   output logic                     SRAM_RE,
   output logic [DATA_W-1:0]        DataToCPUs,
   output logic [NUM_CH-1:0]        requestDone,
   output logic                     busy
);

   localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
      $error("sram_arbiter: ACCESS_CYCLES must be at least 1");
   end
   if (NUM_CH < 2) begin : g_bad_num_ch
      $error("sram_arbiter: NUM_CH must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e            state_q;
   logic [ChW-1:0]    ch_q;
   logic [ChW-1:0]    last_grant_q;
   logic              write_q;
   logic [CntW-1:0]   cnt_q;

   // Unpacked views of the packed per-channel buses.
   logic [ADDR_W-1:0] addr_arr [NUM_CH];
   logic [DATA_W-1:0] data_arr [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign addr_arr[g] = addr_in[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = data_in[g*DATA_W +: DATA_W];
   end

   logic [NUM_CH-1:0] req;
   logic              grant_valid;
   logic [ChW-1:0]    grant_ch;
   logic              grant_write;

   assign req = writeRequest | readRequest;

   // Round-robin search starting one past the last served channel, wrapping mod NUM_CH.
   always_comb begin
      logic [ChW-1:0] idx;
      idx         = '0;
      grant_valid = 1'b0;
      grant_ch    = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         idx = ChW'((32'(last_grant_q) + i) % NUM_CH);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_ch    = idx;
         end
      end
      grant_write = writeRequest[grant_ch];
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         ch_q          <= '0;
         last_grant_q  <= ChW'(NUM_CH - 1);
         write_q       <= 1'b0;
         cnt_q         <= '0;
         addressToSRAM <= '0;
         sram_wdata    <= '0;
         sram_data_oe  <= 1'b0;
         SRAM_WE       <= 1'b1;
         SRAM_RE       <= 1'b1;
         DataToCPUs    <= '0;
         requestDone   <= '0;
         busy          <= 1'b0;
      end else begin
         requestDone <= '0;
         unique case (state_q)
            StIdle: begin
               if (grant_valid) begin
                  ch_q          <= grant_ch;
                  write_q       <= grant_write;
                  addressToSRAM <= addr_arr[grant_ch];
                  if (grant_write) begin
                     sram_wdata <= data_arr[grant_ch];
                  end
                  SRAM_WE      <= ~grant_write;
                  SRAM_RE      <= grant_write;
                  sram_data_oe <= grant_write;
                  cnt_q        <= CntW'(ACCESS_CYCLES - 1);
                  busy         <= 1'b1;
                  state_q      <= StAccess;
               end
            end
            StAccess: begin
               if (cnt_q == '0) begin
                  // Read data is sampled on the same edge that releases the strobe.
                  if (!write_q) begin
                     DataToCPUs <= sram_rdata;
                  end
                  SRAM_WE           <= 1'b1;
                  SRAM_RE           <= 1'b1;
                  sram_data_oe      <= 1'b0;
                  requestDone[ch_q] <= 1'b1;
                  state_q           <= StDone;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StDone: begin
               last_grant_q <= ch_q;
               busy         <= 1'b0;
               state_q      <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

   localparam int NCH = 5;
   localparam int AW  = 16;
   localparam int DW  = 16;

   logic              Clk = 1'b0;
   logic              reset_n;
   logic [NCH-1:0]    wr_req;
   logic [NCH-1:0]    rd_req;
   logic [AW-1:0]     tb_addr [NCH];
   logic [DW-1:0]     tb_data [NCH];
   logic [NCH*AW-1:0] addr_in;
   logic [NCH*DW-1:0] data_in;
   logic [AW-1:0]     addressToSRAM;
   logic [DW-1:0]     sram_wdata;
   logic [DW-1:0]     sram_rdata;
   logic              sram_data_oe;
   logic              SRAM_WE;
   logic              SRAM_RE;
   logic [DW-1:0]     DataToCPUs;
   logic [NCH-1:0]    requestDone;
   logic              busy;

   // Second instance with ACCESS_CYCLES=4.
   logic [NCH-1:0]    u4_wr;
   logic [NCH-1:0]    u4_rd;
   logic [NCH*AW-1:0] u4_addr;
   logic [NCH*DW-1:0] u4_data;
   logic [AW-1:0]     u4_sram_addr;
   logic [DW-1:0]     u4_wdata;
   logic [DW-1:0]     u4_rdata;
   logic              u4_oe;
   logic              u4_we;
   logic              u4_re;
   logic [DW-1:0]     u4_dout;
   logic [NCH-1:0]    u4_done;
   logic              u4_busy;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   for (genvar g = 0; g < NCH; g++) begin : g_pack
      assign addr_in[g*AW +: AW] = tb_addr[g];
      assign data_in[g*DW +: DW] = tb_data[g];
   end

   // Behavioural SRAM: write while WE is low on each clock, combinational read while RE is low.
   logic [DW-1:0] mem [0:65535];
   always @(posedge Clk) begin
      if (!SRAM_WE) mem[addressToSRAM] <= sram_wdata;
   end
   assign sram_rdata = !SRAM_RE ? mem[addressToSRAM] : '0;
   assign u4_rdata   = !u4_re ? 16'h3C3C : 16'h0000;

   sram_arbiter #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2)
   ) dut (
      .Clk(Clk), .reset_n(reset_n),
      .writeRequest(wr_req), .readRequest(rd_req),
      .addr_in(addr_in), .data_in(data_in),
      .addressToSRAM(addressToSRAM), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_data_oe(sram_data_oe), .SRAM_WE(SRAM_WE), .SRAM_RE(SRAM_RE),
      .DataToCPUs(DataToCPUs), .requestDone(requestDone), .busy(busy)
   );

   sram_arbiter #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(4)
   ) dut4 (
      .Clk(Clk), .reset_n(reset_n),
      .writeRequest(u4_wr), .readRequest(u4_rd),
      .addr_in(u4_addr), .data_in(u4_data),
      .addressToSRAM(u4_sram_addr), .sram_wdata(u4_wdata), .sram_rdata(u4_rdata),
      .sram_data_oe(u4_oe), .SRAM_WE(u4_we), .SRAM_RE(u4_re),
      .DataToCPUs(u4_dout), .requestDone(u4_done), .busy(u4_busy)
   );

   typedef struct {
      logic [2:0]  ch;
      logic        wr;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_dout;
      logic        exp_write;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic [2:0] ch, input logic wr, input logic rd,
                          input logic [15:0] a, input logic [15:0] d);
      wr_req[ch]  = wr;
      rd_req[ch]  = rd;
      tb_addr[ch] = a;
      tb_data[ch] = d;
   endtask

   // One isolated transaction on the ACCESS_CYCLES=2 instance, checked cycle by cycle.
   task automatic run_vec(input vec_t v, input string tag);
      logic [4:0] exp_done;
      exp_done = 5'b00001 << v.ch;
      @(negedge Clk);
      set_req(v.ch, v.wr, v.rd, v.addr, v.wdata);
      for (int c = 1; c <= 2; c++) begin
         @(negedge Clk);
         chk($sformatf("%s c%0d addr", tag, c), addressToSRAM, v.addr);
         chk($sformatf("%s c%0d we", tag, c), SRAM_WE, !v.exp_write);
         chk($sformatf("%s c%0d re", tag, c), SRAM_RE, v.exp_write);
         chk($sformatf("%s c%0d oe", tag, c), sram_data_oe, v.exp_write);
         chk($sformatf("%s c%0d done", tag, c), requestDone, 5'b0);
         if (v.exp_write) chk($sformatf("%s c%0d wdata", tag, c), sram_wdata, v.wdata);
      end
      @(negedge Clk);
      chk({tag, " done"}, requestDone, exp_done);
      chk({tag, " dout"}, DataToCPUs, v.exp_dout);
      chk({tag, " strobes"}, {SRAM_WE, SRAM_RE, sram_data_oe}, 3'b110);
      chk({tag, " addr hold"}, addressToSRAM, v.addr);
      set_req(v.ch, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge Clk);
      chk({tag, " idle busy"}, busy, 1'b0);
   endtask

   // Waits a bounded number of cycles for any requestDone pulse; deasserts the finished channel.
   task automatic wait_done(output logic [4:0] got);
      got = '0;
      for (int t = 0; t < 12 && got == '0; t++) begin
         @(negedge Clk);
         got = requestDone;
      end
      for (int i = 0; i < NCH; i++) begin
         if (got[i]) set_req(3'(i), 1'b0, 1'b0, 16'h0, 16'h0);
      end
   endtask

   task automatic rr(input logic [4:0] mask, input int n, input int exp_order [5], input string tag);
      logic [4:0] got;
      @(negedge Clk);
      for (int i = 0; i < NCH; i++) begin
         if (mask[i]) set_req(3'(i), 1'b1, 1'b0, 16'h0300 + 16'(i), 16'h7700 + 16'(i));
      end
      for (int k = 0; k < n; k++) begin
         wait_done(got);
         chk($sformatf("%s grant%0d", tag, k), got, 5'b00001 << exp_order[k]);
      end
   endtask

   initial begin
      logic [4:0] got;
      int         ord [5];
      reset_n = 1'b0;
      wr_req  = '0;
      rd_req  = '0;
      u4_wr   = '0;
      u4_rd   = '0;
      u4_addr = '0;
      u4_data = '0;
      for (int i = 0; i < NCH; i++) begin
         tb_addr[i] = '0;
         tb_data[i] = '0;
      end

      vecs[0] = '{3'd2, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b1};
      vecs[1] = '{3'd2, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      vecs[2] = '{3'd1, 1'b1, 1'b1, 16'h0010, 16'h5555, 16'hBEEF, 1'b1};
      vecs[3] = '{3'd1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h5555, 1'b0};
      vecs[4] = '{3'd4, 1'b1, 1'b0, 16'hFFFF, 16'hA5A5, 16'h5555, 1'b1};
      vecs[5] = '{3'd3, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hA5A5, 1'b0};
      vecs[6] = '{3'd0, 1'b1, 1'b0, 16'h0200, 16'hCAFE, 16'hA5A5, 1'b1};
      vecs[7] = '{3'd0, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'hCAFE, 1'b0};

      repeat (2) @(negedge Clk);
      chk("rst strobes", {SRAM_WE, SRAM_RE, sram_data_oe}, 3'b110);
      chk("rst addr", addressToSRAM, 16'h0);
      chk("rst wdata", sram_wdata, 16'h0);
      chk("rst dout", DataToCPUs, 16'h0);
      chk("rst done", requestDone, 5'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst4 strobes", {u4_we, u4_re, u4_oe, u4_busy}, 4'b1100);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Round-robin out of reset.
      @(negedge Clk);
      reset_n = 1'b0;
      @(negedge Clk);
      reset_n = 1'b1;
      ord = '{0, 1, 2, 3, 4};
      rr(5'b11111, 5, ord, "rr_all_a");
      rr(5'b11111, 5, ord, "rr_all_b");
      run_vec('{3'd1, 1'b0, 1'b1, 16'h0301, 16'h0000, 16'h7701, 1'b0}, "rr_set1");
      ord = '{3, 0, 1, 0, 0};
      rr(5'b01011, 3, ord, "rr_sub");

      // Address/data change after grant must not reach the SRAM.
      @(negedge Clk);
      set_req(3'd0, 1'b1, 1'b0, 16'h0100, 16'h1234);
      @(negedge Clk);
      chk("mid we", SRAM_WE, 1'b0);
      tb_addr[0] = 16'hFFFF;
      tb_data[0] = 16'hFFFF;
      @(negedge Clk);
      chk("mid addr", addressToSRAM, 16'h0100);
      chk("mid wdata", sram_wdata, 16'h1234);
      wait_done(got);
      chk("mid done", got, 5'b00001);
      repeat (2) @(negedge Clk);
      chk("mid mem0100", mem[16'h0100], 16'h1234);
      chk("mid memFFFF", mem[16'hFFFF], 16'hA5A5);

      // Reset in the middle of a write.
      @(negedge Clk);
      set_req(3'd0, 1'b1, 1'b0, 16'h0400, 16'h4321);
      @(negedge Clk);
      chk("rstmid we before", SRAM_WE, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk("rstmid we", SRAM_WE, 1'b1);
      chk("rstmid oe", sram_data_oe, 1'b0);
      chk("rstmid done", requestDone, 5'b0);
      @(negedge Clk);
      chk("rstmid done2", requestDone, 5'b0);
      reset_n = 1'b1;
      set_req(3'd1, 1'b1, 1'b0, 16'h0500, 16'h6789);
      wait_done(got);
      chk("rstmid first", got, 5'b00001);
      wait_done(got);
      chk("rstmid second", got, 5'b00010);

      // ACCESS_CYCLES=4 read timing.
      @(negedge Clk);
      u4_rd[3] = 1'b1;
      u4_addr[3*AW +: AW] = 16'h0042;
      for (int c = 1; c <= 7; c++) begin
         @(negedge Clk);
         chk($sformatf("ac4 c%0d re", c), u4_re, (c <= 4) ? 1'b0 : 1'b1);
         chk($sformatf("ac4 c%0d we", c), {u4_we, u4_oe}, 2'b10);
         chk($sformatf("ac4 c%0d busy", c), u4_busy, (c <= 5) ? 1'b1 : 1'b0);
         chk($sformatf("ac4 c%0d done", c), u4_done, (c == 5) ? 5'b01000 : 5'b00000);
         if (c <= 5) chk($sformatf("ac4 c%0d addr", c), u4_sram_addr, 16'h0042);
         if (c == 5) begin
            chk("ac4 dout", u4_dout, 16'h3C3C);
            u4_rd[3] = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
